// File: rtl/reg_cmd_ctrl_if.sv
// reg_cmd_ctrl_if: byte command stream, register-file and transmit signals.
// slave = controller side, master = environment side.
interface reg_cmd_ctrl_if #(
  parameter int address_width = 4,
  parameter int data_width    = 8
);
  logic [data_width-1:0]    RX_P_DATA;
  logic                     RX_D_VLD;
  logic [data_width-1:0]    RdData;
  logic                     RdData_Valid;
  logic                     TX_BUSY;
  logic                     WrEn;
  logic                     RdEn;
  logic [address_width-1:0] Address;
  logic [data_width-1:0]    WrData;
  logic [data_width-1:0]    TX_P_DATA;
  logic                     TX_D_VLD;
  logic                     CTRL_BUSY;

  modport slave (
    input  RX_P_DATA, RX_D_VLD, RdData,
    input  RdData_Valid, TX_BUSY,
    output WrEn, RdEn, Address, WrData,
    output TX_P_DATA, TX_D_VLD, CTRL_BUSY
  );

  modport master (
    output RX_P_DATA, RX_D_VLD, RdData,
    output RdData_Valid, TX_BUSY,
    input  WrEn, RdEn, Address, WrData,
    input  TX_P_DATA, TX_D_VLD, CTRL_BUSY
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: byte-command decoder driving a register file (0xAA write,
// 0xBB read + reply). Define WR_ECHO_EN to echo written data on TX.
module reg_cmd_ctrl #(
  parameter int address_width = 4,
  parameter int data_width    = 8
) (
  input  logic         CLK,
  input  logic         RST,
  reg_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  localparam logic [data_width-1:0] CMD_WR  = data_width'(8'hAA);
  localparam logic [data_width-1:0] CMD_RD  = data_width'(8'hBB);
  localparam logic [data_width-1:0] TO_BYTE = data_width'(8'hFF);

  state_t                   state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    wdata_q, wdata_d;
  logic [data_width-1:0]    txd_q, txd_d;
  logic                     wren_q, wren_d;
  logic                     rden_q, rden_d;
  logic [2:0]               cnt_q, cnt_d;

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state and register updates; pulses default low
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_WR)
            state_d = WR_ADDR;
          else if (bus.RX_P_DATA == CMD_RD)
            state_d = RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d  = bus.RX_P_DATA[address_width-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wdata_d = bus.RX_P_DATA;
          wren_d  = 1'b1;
`ifdef WR_ECHO_EN
          txd_d   = bus.RX_P_DATA;
          state_d = TX_SEND;
`else
          state_d = IDLE;
`endif
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_d  = bus.RX_P_DATA[address_width-1:0];
          rden_d  = 1'b1;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.RdData_Valid) begin
          txd_d   = bus.RdData;
          cnt_d   = '0;
          state_d = TX_SEND;
        end else if (cnt_q == 3'd7) begin
          txd_d   = TO_BYTE;
          cnt_d   = '0;
          state_d = TX_SEND;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      TX_SEND: begin
        if (!bus.TX_BUSY)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.WrEn      = wren_q;
  assign bus.RdEn      = rden_q;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wdata_q;
  assign bus.TX_P_DATA = txd_q;
  assign bus.TX_D_VLD  = (state_q == TX_SEND) && !bus.TX_BUSY;
  assign bus.CTRL_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: randomized command traffic against a
// transaction-level expectation of writes, reads and replies.
module tb_reg_cmd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef WR_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  reg_cmd_ctrl_if #(.address_width(AW), .data_width(DW)) bus ();

  reg_cmd_ctrl #(.address_width(AW), .data_width(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit overlap = 1'b0;

  int wa_q[$], wd_q[$], wc_q[$];
  int ra_q[$], rc_q[$];
  int td_q[$], tc_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // event log sampled mid-cycle
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.WrEn) begin
        wa_q.push_back(int'(bus.Address));
        wd_q.push_back(int'(bus.WrData));
        wc_q.push_back(cyc);
      end
      if (bus.RdEn) begin
        ra_q.push_back(int'(bus.Address));
        rc_q.push_back(cyc);
      end
      if (bus.TX_D_VLD) begin
        td_q.push_back(int'(bus.TX_P_DATA));
        tc_q.push_back(cyc);
      end
      if (bus.WrEn && bus.RdEn) overlap = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000");
    $fatal(1);
  end

  task automatic clr_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    ra_q.delete(); rc_q.delete();
    td_q.delete(); tc_q.delete();
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    step();
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.CTRL_BUSY && n < 60) begin
      step();
      n++;
    end
    step();
    step();
    tests++;
    if (bus.CTRL_BUSY !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: CTRL_BUSY=%b want 0", nm, bus.CTRL_BUSY);
    end
  endtask

  task automatic test_reset();
    bus.RX_P_DATA    = '0;
    bus.RX_D_VLD     = 1'b0;
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    bus.TX_BUSY      = 1'b0;
    RST = 1'b0;
    #3;
    tests++;
    if ({bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.CTRL_BUSY} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 0000",
        {bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.CTRL_BUSY});
    end
    tests++;
    if ({bus.Address, bus.WrData, bus.TX_P_DATA} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wd=%h tx=%h want 0",
        bus.Address, bus.WrData, bus.TX_P_DATA);
    end
    step();
    RST = 1'b1;
    step();
  endtask

  task automatic test_write(input logic [7:0] a, input logic [7:0] d,
                            input string nm);
    int w;
    int ea;
    ea = int'(a) % (1 << AW);
    clr_log();
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    w = cyc;
    wait_idle(nm);
    tests++;
    if (wa_q.size() != 1) begin
      fails++;
      $display("FAIL %s wr_count: got %0d want 1", nm, wa_q.size());
    end else begin
      tests++;
      if (wa_q[0] != ea || wd_q[0] != int'(d) || wc_q[0] != w) begin
        fails++;
        $display("FAIL %s wr: addr=%0d data=%h cyc=%0d want %0d %h %0d",
          nm, wa_q[0], wd_q[0], wc_q[0], ea, d, w);
      end
    end
    tests++;
    if (ra_q.size() != 0) begin
      fails++;
      $display("FAIL %s rd_count: got %0d want 0", nm, ra_q.size());
    end
    tests++;
    if (td_q.size() != int'(ECHO)) begin
      fails++;
      $display("FAIL %s tx_count: got %0d want %0d", nm, td_q.size(),
        int'(ECHO));
    end else if (ECHO) begin
      tests++;
      if (td_q[0] != int'(d) || tc_q[0] != w) begin
        fails++;
        $display("FAIL %s echo: data=%h cyc=%0d want %h %0d",
          nm, td_q[0], tc_q[0], d, w);
      end
    end
  endtask

  task automatic test_read(input logic [7:0] a, input logic [7:0] d,
                           input int delay, input int busy_len,
                           input string nm);
    int c, ea, ed, et, rel;
    ea  = int'(a) % (1 << AW);
    ed  = (delay <= 7) ? int'(d) : 255;
    et  = (delay <= 7) ? delay + 1 : 8;
    rel = et + busy_len;
    et  = et + busy_len;
    clr_log();
    bus.TX_BUSY = (busy_len > 0);
    send_byte(8'hBB);
    send_byte(a);
    c = cyc;
    for (int k = 0; k < 12 + busy_len; k++) begin
      bus.RX_P_DATA    = (k == 0) ? 8'hAA : 8'hBB;
      bus.RX_D_VLD     = (k == 0) || (busy_len > 0 && k == 5);
      bus.RdData_Valid = (k == delay);
      bus.RdData       = (k == delay) ? d : 8'($urandom);
      if (busy_len > 0 && k == rel) bus.TX_BUSY = 1'b0;
      step();
    end
    bus.RX_D_VLD     = 1'b0;
    bus.RdData_Valid = 1'b0;
    bus.TX_BUSY      = 1'b0;
    wait_idle(nm);
    tests++;
    if (ra_q.size() != 1) begin
      fails++;
      $display("FAIL %s rd_count: got %0d want 1", nm, ra_q.size());
    end else begin
      tests++;
      if (ra_q[0] != ea || rc_q[0] != c) begin
        fails++;
        $display("FAIL %s rd: addr=%0d cyc=%0d want %0d %0d",
          nm, ra_q[0], rc_q[0], ea, c);
      end
    end
    tests++;
    if (wa_q.size() != 0) begin
      fails++;
      $display("FAIL %s wr_count: got %0d want 0", nm, wa_q.size());
    end
    tests++;
    if (td_q.size() != 1) begin
      fails++;
      $display("FAIL %s tx_count: got %0d want 1", nm, td_q.size());
    end else begin
      tests++;
      if (td_q[0] != ed || tc_q[0] != c + et) begin
        fails++;
        $display("FAIL %s tx: data=%h cyc=%0d want %h %0d",
          nm, td_q[0], tc_q[0], ed, c + et);
      end
    end
  endtask

  task automatic test_junk();
    clr_log();
    send_byte(8'h12);
    step();
    step();
    tests++;
    if (bus.CTRL_BUSY !== 1'b0 ||
        wa_q.size() + ra_q.size() + td_q.size() != 0) begin
      fails++;
      $display("FAIL junk: busy=%b events=%0d want 0 0", bus.CTRL_BUSY,
        wa_q.size() + ra_q.size() + td_q.size());
    end
    test_write(8'hF3, 8'h99, "trunc_write");
  endtask

  task automatic test_reset_mid();
    clr_log();
    send_byte(8'hAA);
    send_byte(8'h04);
    #2;
    RST = 1'b0;
    #1;
    tests++;
    if ({bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.CTRL_BUSY} !== 4'b0) begin
      fails++;
      $display("FAIL midrst_ctl: got %b want 0000",
        {bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.CTRL_BUSY});
    end
    tests++;
    if ({bus.Address, bus.WrData, bus.TX_P_DATA} !== '0) begin
      fails++;
      $display("FAIL midrst_data: addr=%h wd=%h tx=%h want 0",
        bus.Address, bus.WrData, bus.TX_P_DATA);
    end
    step();
    RST = 1'b1;
    step();
    send_byte(8'h3C);
    step();
    step();
    tests++;
    if (wa_q.size() != 0 || bus.CTRL_BUSY !== 1'b0) begin
      fails++;
      $display("FAIL midrst_abort: wr=%0d busy=%b want 0 0",
        wa_q.size(), bus.CTRL_BUSY);
    end
    test_read(8'h06, 8'h5A, 3, 0, "after_rst_read");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0)
        test_write(a, d, "rand_write");
      else
        test_read(a, d, int'($urandom_range(0, 10)), 0, "rand_read");
    end
  endtask

  initial begin
    test_reset();
    test_write(8'h05, 8'h3C, "write");
    test_read(8'h02, 8'h81, 2, 0, "read");
    test_read(8'h07, 8'h42, 11, 0, "timeout");
    test_read(8'h07, 8'h42, 7, 0, "last_slot");
    test_read(8'h09, 8'hC3, 2, 20, "backpressure");
    test_junk();
    test_reset_mid();
    test_random();
    tests++;
    if (overlap) begin
      fails++;
      $display("FAIL wr_rd_overlap: got 1 want 0");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter address_width, default 4, meaning register-file address width in bits.
REQ-002 The block SHALL have parameter data_width, default 8, meaning command/data byte width in bits.
REQ-003 The block SHALL have port CLK  input  1  single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port RX_P_DATA  input  data_width  incoming command/operand byte.
REQ-006 The block SHALL have port RX_D_VLD  input  1  RX_P_DATA valid, single-cycle pulse per byte.
REQ-007 The block SHALL have port RdData  input  data_width  register-file read data.
REQ-008 The block SHALL have port RdData_Valid  input  1  register-file read data valid, single-cycle pulse.
REQ-009 The block SHALL have port TX_BUSY  input  1  transmitter busy, holds TX_D_VLD off while high.
REQ-010 The block SHALL have port WrEn  output  1  register-file write enable.
REQ-011 The block SHALL have port RdEn  output  1  register-file read enable.
REQ-012 The block SHALL have port Address  output  address_width  register-file address.
REQ-013 The block SHALL have port WrData  output  data_width  register-file write data.
REQ-014 The block SHALL have port TX_P_DATA  output  data_width  byte to transmit.
REQ-015 The block SHALL have port TX_D_VLD  output  1  TX_P_DATA valid, single-cycle pulse.
REQ-016 The block SHALL have port CTRL_BUSY  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-018 In IDLE, byte 0xAA with RX_D_VLD SHALL go to WR_ADDR; 0xBB SHALL go to RD_ADDR; any other byte SHALL be dropped, remaining in IDLE.
REQ-019 In WR_ADDR, the next valid byte's low address_width bits SHALL be latched into Address; go to WR_DATA.
REQ-020 In WR_DATA, the next valid byte SHALL be driven on WrData with WrEn high for exactly one cycle (the cycle after the byte is accepted); then return to IDLE.
REQ-021 In RD_ADDR, the next valid byte SHALL be latched into Address, then RdEn SHALL pulse high for exactly one cycle; go to RD_WAIT.
REQ-022 In RD_WAIT, on RdData_Valid, RdData SHALL be captured into TX_P_DATA; go to TX_SEND.
REQ-023 RD_WAIT SHALL time out after 8 cycles without RdData_Valid; TX_P_DATA SHALL be set to 0xFF and go to TX_SEND.
REQ-024 In TX_SEND, TX_D_VLD SHALL pulse one cycle in the first cycle TX_BUSY is low; go to IDLE the cycle after that pulse.
REQ-025 WrEn and RdEn SHALL never be high in the same cycle.
REQ-026 RX_D_VLD arriving in RD_WAIT or TX_SEND SHALL be ignored.
REQ-027 Upper bits of address bytes beyond address_width SHALL be discarded; no error is raised.
REQ-028 WrData, Address, and TX_P_DATA SHALL hold their last values when not being updated.

Reset
REQ-029 On RST low, the state SHALL become IDLE; WrEn, RdEn, TX_D_VLD, and CTRL_BUSY SHALL be 0; Address, WrData, and TX_P_DATA SHALL be 0; the timeout counter SHALL be 0.
REQ-030 Reset asserted mid-command SHALL abort the command with no WrEn/RdEn/TX_D_VLD pulse issued afterward.

Configuration
REQ-031 Macro WR_ECHO_EN SHALL control write acknowledgement.
- Defined: after the WrEn pulse, WR_DATA SHALL go to TX_SEND with TX_P_DATA = written data (echo).
- Undefined: WR_DATA SHALL return directly to IDLE and no byte SHALL be transmitted for writes.

Verification
REQ-032 Write: bytes 0xAA, 0x05, 0x3C -> one WrEn pulse with Address=5, WrData=0x3C; with WR_ECHO_EN, TX_P_DATA=0x3C with one TX_D_VLD.
REQ-033 Read: bytes 0xBB, 0x02, RdData=0x81 with RdData_Valid 2 cycles after RdEn -> one RdEn pulse, Address=2, TX_P_DATA=0x81 with one TX_D_VLD.
REQ-034 Timeout: 0xBB, 0x07, no RdData_Valid -> TX_P_DATA=0xFF sent 8 cycles after RdEn.
REQ-035 Backpressure: read completes while TX_BUSY is high for 20 cycles -> TX_D_VLD is issued in the first cycle after TX_BUSY falls, exactly once.
REQ-036 Junk and address truncation: 0x12 in IDLE -> no outputs; then 0xAA, 0xF3, 0x99 -> write to Address=3.
REQ-037 Reset mid-command: 0xAA, 0x04, then RST low before the data byte -> no WrEn; all outputs are 0; the next 0xBB command operates normally.
